// File: rtl/check_node_sched.sv
// rtl/check_node_sched.sv - degree-6 min-sum check node sequencer with one shared evaluator
module check_node_sched #(
   parameter int WIDTH  = 20,
   parameter int OFFSET = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [2:0]       out_edge,
   output logic             busy
);

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      EVAL = 2'd1,
      EMIT = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] OFF_W = WIDTH'(OFFSET);

   state_t           state_q, state_d;
   logic [2:0]       ld_cnt_q, ld_cnt_d;
   logic [WIDTH-1:0] msg_q [6];
   logic [WIDTH-1:0] msg_d [6];
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [2:0]       out_edge_q, out_edge_d;

   logic [2:0]       excl_edge;
   logic [WIDTH-1:0] abs_v;
   logic [WIDTH-1:0] mag;
   logic [WIDTH-1:0] mag2;
   logic             sign;
   logic [WIDTH-1:0] eval_result;

   // Shared evaluator: result for the edge whose value is registered next
   // (edge 0 while in EVAL, otherwise the edge after the one on display).
   always_comb begin
      excl_edge = (state_q == EVAL) ? 3'd0 : out_edge_q + 3'd1;
      mag       = '1;
      sign      = 1'b0;
      abs_v     = '0;
      for (int j = 0; j < 6; j++) begin
         if (3'(j) != excl_edge) begin
            // Two's complement negation wraps the most negative value onto
            // itself, which read unsigned is exactly its magnitude.
            abs_v = msg_q[j][WIDTH-1] ? (~msg_q[j] + 1'b1) : msg_q[j];
            if (abs_v < mag) begin
               mag = abs_v;
            end
            sign = sign ^ msg_q[j][WIDTH-1];
         end
      end
      mag2        = (mag > OFF_W) ? (mag - OFF_W) : '0;
      eval_result = sign ? (~mag2 + 1'b1) : mag2;
   end

   // Next-state logic: load sequencing, evaluation and emit handshakes, with clear on top.
   always_comb begin
      state_d    = state_q;
      ld_cnt_d   = ld_cnt_q;
      msg_d      = msg_q;
      out_data_d = out_data_q;
      out_edge_d = out_edge_q;
      if (clear) begin
         state_d    = LOAD;
         ld_cnt_d   = 3'd0;
         out_edge_d = 3'd0;
      end else begin
         case (state_q)
            LOAD: begin
               if (in_valid) begin
                  msg_d[ld_cnt_q] = in_data;
                  if (ld_cnt_q == 3'd5) begin
                     ld_cnt_d = 3'd0;
                     state_d  = EVAL;
                  end else begin
                     ld_cnt_d = ld_cnt_q + 3'd1;
                  end
               end
            end
            EVAL: begin
               out_data_d = eval_result;
               out_edge_d = 3'd0;
               state_d    = EMIT;
            end
            EMIT: begin
               if (out_ready) begin
                  if (out_edge_q == 3'd5) begin
                     state_d = LOAD;
                  end else begin
                     out_edge_d = out_edge_q + 3'd1;
                     out_data_d = eval_result;
                  end
               end
            end
            default: begin
               state_d  = LOAD;
               ld_cnt_d = 3'd0;
            end
         endcase
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= LOAD;
         ld_cnt_q   <= 3'd0;
         out_data_q <= '0;
         out_edge_q <= 3'd0;
         for (int i = 0; i < 6; i++) begin
            msg_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         ld_cnt_q   <= ld_cnt_d;
         out_data_q <= out_data_d;
         out_edge_q <= out_edge_d;
         for (int i = 0; i < 6; i++) begin
            msg_q[i] <= msg_d[i];
         end
      end
   end

   assign in_ready  = (state_q == LOAD);
   assign out_valid = (state_q == EMIT);
   assign out_data  = out_data_q;
   assign out_edge  = out_edge_q;
   assign busy      = (state_q != LOAD) || (ld_cnt_q != 3'd0);

endmodule

// File: tb/tb_check_node_sched.sv
// tb/tb_check_node_sched.sv - bench for check_node_sched (offset 0 and offset 1 instances)
module tb_check_node_sched;

   typedef logic [5:0][7:0] frame_t;

   typedef struct packed {
      frame_t m;
      frame_t e0;
      frame_t e1;
      logic   gaps;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clear = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'd0;
   logic       out_ready = 1'b0;

   logic       in_ready0, out_valid0, busy0;
   logic [7:0] out_data0;
   logic [2:0] out_edge0;
   logic       in_ready1, out_valid1, busy1;
   logic [7:0] out_data1;
   logic [2:0] out_edge1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   check_node_sched #(.WIDTH(8), .OFFSET(0)) dut0 (
      .clk(clk), .rst(rst), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
      .out_valid(out_valid0), .out_ready(out_ready),
      .out_data(out_data0), .out_edge(out_edge0), .busy(busy0)
   );

   check_node_sched #(.WIDTH(8), .OFFSET(1)) dut1 (
      .clk(clk), .rst(rst), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
      .out_valid(out_valid1), .out_ready(out_ready),
      .out_data(out_data1), .out_edge(out_edge1), .busy(busy1)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic frame_t p6(input int a0, input int a1, input int a2,
                                 input int a3, input int a4, input int a5);
      frame_t r;
      r[0] = 8'(a0); r[1] = 8'(a1); r[2] = 8'(a2);
      r[3] = 8'(a3); r[4] = 8'(a4); r[5] = 8'(a5);
      return r;
   endfunction

   // Reference: min-sum over the other five edges using plain integer arithmetic.
   function automatic logic [7:0] model(input frame_t m, input int k, input int off);
      int mn, neg, v, a, mag2;
      logic [7:0] r;
      mn  = 1 << 20;
      neg = 0;
      for (int j = 0; j < 6; j++) begin
         if (j != k) begin
            v = int'($signed(m[j]));
            a = (v < 0) ? -v : v;
            if (a < mn) mn = a;
            if (v < 0) neg++;
         end
      end
      mag2 = (mn > off) ? mn - off : 0;
      v = (neg % 2 == 1) ? -mag2 : mag2;
      r = v[7:0];
      return r;
   endfunction

   function automatic frame_t model_frame(input frame_t m, input int off);
      frame_t r;
      for (int k = 0; k < 6; k++) r[k] = model(m, k, off);
      return r;
   endfunction

   task automatic load_frame(input frame_t m, input bit gaps);
      for (int i = 0; i < 6; i++) begin
         if (gaps) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
               in_valid = 1'b0;
               in_data  = 8'($urandom);
               step();
            end
         end
         in_valid = 1'b1;
         in_data  = m[i];
         chk("in_ready_load", {31'd0, in_ready0 & in_ready1}, 1);
         step();
      end
      in_valid = 1'b0;
   endtask

   task automatic collect(input frame_t e0, input frame_t e1, input bit gaps);
      int k, cycles;
      bit r;
      chk("eval_out_valid", {31'd0, out_valid0 | out_valid1}, 0);
      chk("eval_in_ready", {31'd0, in_ready0 | in_ready1}, 0);
      chk("eval_busy", {31'd0, busy0 & busy1}, 1);
      out_ready = 1'b1;
      step();
      k = 0;
      cycles = 0;
      while (k < 6 && cycles < 200) begin
         cycles++;
         if (!(out_valid0 && out_valid1)) begin
            chk("emit_out_valid", {30'd0, out_valid1, out_valid0}, 3);
            break;
         end
         chk("emit_in_ready", {30'd0, in_ready1, in_ready0}, 0);
         chk("out_edge0", int'(out_edge0), k);
         chk("out_edge1", int'(out_edge1), k);
         chk("out_data0", int'(out_data0), int'(e0[k]));
         chk("out_data1", int'(out_data1), int'(e1[k]));
         r = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         out_ready = r;
         in_valid  = gaps ? 1'($urandom) : 1'b0;
         in_data   = 8'($urandom);
         step();
         if (r) k++;
      end
      chk("emit_count", k, 6);
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk("done_out_valid", {30'd0, out_valid1, out_valid0}, 0);
      chk("done_in_ready", {30'd0, in_ready1, in_ready0}, 3);
      chk("done_busy", {30'd0, busy1, busy0}, 0);
   endtask

   vec_t   tbl[4];
   frame_t basic, m;

   initial begin
      basic = p6(3, -5, 7, -2, 9, 4);
      tbl[0] = '{m: basic, e0: p6(2, -2, 2, -3, 2, 2), e1: p6(1, -1, 1, -2, 1, 1), gaps: 1'b0};
      tbl[1] = '{m: p6(-128, -128, -128, -128, -128, -128),
                 e0: p6(-128, -128, -128, -128, -128, -128),
                 e1: p6(-127, -127, -127, -127, -127, -127), gaps: 1'b0};
      tbl[2] = '{m: p6(1, 1, 1, 1, 1, -1), e0: p6(-1, -1, -1, -1, -1, 1),
                 e1: p6(0, 0, 0, 0, 0, 0), gaps: 1'b0};
      tbl[3] = '{m: basic, e0: p6(2, -2, 2, -3, 2, 2), e1: p6(1, -1, 1, -2, 1, 1), gaps: 1'b1};

      #12;
      rst = 1'b0;
      step();
      chk("rst_in_ready", {30'd0, in_ready1, in_ready0}, 3);
      chk("rst_out_valid", {30'd0, out_valid1, out_valid0}, 0);
      chk("rst_out_data", int'(out_data0) + int'(out_data1), 0);
      chk("rst_out_edge", int'(out_edge0) + int'(out_edge1), 0);
      chk("rst_busy", {30'd0, busy1, busy0}, 0);

      for (int t = 0; t < 4; t++) begin
         load_frame(tbl[t].m, tbl[t].gaps);
         collect(tbl[t].e0, tbl[t].e1, tbl[t].gaps);
      end

      // Clear after three beats, with a handshake offered in the clear cycle.
      load_frame(p6(-1, -1, -1, 0, 0, 0), 1'b0);
      for (int i = 0; i < 0; i++) step();
      clear = 1'b0;
      // (above frame complete; run clear mid-load on the next one)
      collect(model_frame(p6(-1, -1, -1, 0, 0, 0), 0), model_frame(p6(-1, -1, -1, 0, 0, 0), 1), 1'b0);
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = 8'(100 + i);
         step();
      end
      chk("pre_clear_busy", {30'd0, busy1, busy0}, 3);
      clear    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'd1;
      #1;
      chk("clear_in_ready", {30'd0, in_ready1, in_ready0}, 3);
      step();
      clear    = 1'b0;
      in_valid = 1'b0;
      chk("post_clear_busy", {30'd0, busy1, busy0}, 0);
      load_frame(basic, 1'b0);
      collect(tbl[0].e0, tbl[0].e1, 1'b0);

      // Clear during EMIT while out_edge is 2.
      load_frame(basic, 1'b0);
      out_ready = 1'b1;
      step();
      step();
      step();
      chk("pre_clear_edge", int'(out_edge0), 2);
      clear = 1'b1;
      step();
      clear     = 1'b0;
      out_ready = 1'b0;
      chk("clr_emit_out_valid", {30'd0, out_valid1, out_valid0}, 0);
      chk("clr_emit_in_ready", {30'd0, in_ready1, in_ready0}, 3);
      chk("clr_emit_edge", int'(out_edge0) + int'(out_edge1), 0);

      // Asynchronous reset between clock edges during EMIT.
      load_frame(basic, 1'b0);
      step();
      chk("pre_rst_out_valid", {30'd0, out_valid1, out_valid0}, 3);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_out_valid", {30'd0, out_valid1, out_valid0}, 0);
      chk("arst_in_ready", {30'd0, in_ready1, in_ready0}, 3);
      chk("arst_out_data", int'(out_data0) + int'(out_data1), 0);
      step();
      rst = 1'b0;
      step();
      load_frame(basic, 1'b0);
      collect(tbl[0].e0, tbl[0].e1, 1'b0);

      // Random frames against the reference model.
      for (int f = 0; f < 24; f++) begin
         for (int i = 0; i < 6; i++) begin
            m[i] = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
         end
         load_frame(m, f[0]);
         collect(model_frame(m, 0), model_frame(m, 1), f[0]);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
